// File: rtl/gpu_pkg.sv
// Shared types and helpers for the GPU framebuffer write path.
package gpu_pkg;

   localparam int unsigned FB_ADDR_WIDTH  = 20;
   localparam int unsigned COMP_MAX_WIDTH = 64;

   // Packed RGBA8888 pixel, red in the low byte.
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } rgba8888_t;

   // One framebuffer write: word address plus packed pixel.
   typedef struct packed {
      logic [FB_ADDR_WIDTH-1:0] addr;
      rgba8888_t                data;
   } fb_wr_t;

   // Fixed-point colour component to unsigned 8 bits: negative -> 0, clamp at 255.
   function automatic logic [7:0] sat_to_u8(input logic signed [COMP_MAX_WIDTH-1:0] c,
                                            input int unsigned frac_bits);
      logic [COMP_MAX_WIDTH-1:0] v;
      if (c < 0) return 8'd0;
      v = $unsigned(c) >> (frac_bits - 32'd8);
      if (v > COMP_MAX_WIDTH'(255)) return 8'hFF;
      return v[7:0];
   endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is allowed with a same-cycle pop.
module gpu_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data_c,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [CNT_W-1:0] count_next;

   assign do_pop      = pop && !empty;
   assign do_push     = push && (!full || do_pop);
   assign count_next  = count + CNT_W'(do_push) - CNT_W'(do_pop);
   assign head_data_c = mem[rd_ptr];

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers, occupancy and registered full/empty flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
         full  <= (count_next == CNT_W'(DEPTH));
         empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/fb_pixel_writer.sv
// Terminates the shader pixel stream: clip, convert to RGBA8888, buffer, write to framebuffer.
module fb_pixel_writer
   import gpu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned VEC_SIZE        = 4,
   parameter int unsigned CORD_WIDTH      = 10,
   parameter int unsigned COLOR_FRAC_BITS = 8,
   parameter int unsigned FB_WIDTH        = 640,
   parameter int unsigned FB_HEIGHT       = 480,
   parameter int unsigned ADDR_WIDTH      = 20,
   parameter int unsigned FIFO_DEPTH      = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_pixel_valid,
   input  logic [CORD_WIDTH-1:0]          i_pixel_x,
   input  logic [CORD_WIDTH-1:0]          i_pixel_y,
   input  logic [VEC_SIZE*DATA_WIDTH-1:0] i_pixel_color,
   output logic                           o_fb_wr_valid,
   input  logic                           i_fb_wr_ready,
   output logic [ADDR_WIDTH-1:0]          o_fb_wr_addr,
   output logic [31:0]                    o_fb_wr_data,
   output logic                           o_fifo_almost_full,
   output logic                           o_overflow,
   input  logic                           i_clear_overflow,
   output logic [15:0]                    o_clip_count
);

   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned ENTRY_W = $bits(fb_wr_t);

   // Parameter combinations this datapath cannot honour.
   if (VEC_SIZE != 4 || COLOR_FRAC_BITS < 8 || ADDR_WIDTH != FB_ADDR_WIDTH ||
       DATA_WIDTH > COMP_MAX_WIDTH) begin : g_bad_params
      $error("fb_pixel_writer: unsupported parameter combination");
   end

   logic signed [31:0] x_ext;
   logic signed [31:0] y_ext;
   logic               in_range;
   logic               pix_ok;
   logic               pix_clip;
   logic [7:0]         chan [VEC_SIZE];
   fb_wr_t             push_entry;
   fb_wr_t             head_entry;
   logic [ENTRY_W-1:0] head_raw;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   occ_next;
   logic               drop;

   // Clip test on sign-extended coordinates.
   assign x_ext    = 32'($signed(i_pixel_x));
   assign y_ext    = 32'($signed(i_pixel_y));
   assign in_range = (x_ext >= 0) && (y_ext >= 0) &&
                     ($unsigned(x_ext) < FB_WIDTH) && ($unsigned(y_ext) < FB_HEIGHT);
   assign pix_ok   = i_pixel_valid && in_range;
   assign pix_clip = i_pixel_valid && !in_range;

   // Per-component saturation to 8 bits.
   for (genvar i = 0; i < VEC_SIZE; i++) begin : g_chan
      assign chan[i] = sat_to_u8(COMP_MAX_WIDTH'($signed(i_pixel_color[i*DATA_WIDTH +: DATA_WIDTH])),
                                 COLOR_FRAC_BITS);
   end

   // Entry written into the FIFO: linear address plus packed colour.
   always_comb begin
      push_entry        = '0;
      push_entry.addr   = FB_ADDR_WIDTH'($unsigned(y_ext) * FB_WIDTH + $unsigned(x_ext));
      push_entry.data.r = chan[0];
      push_entry.data.g = chan[1];
      push_entry.data.b = chan[2];
      push_entry.data.a = chan[3];
   end

   // A full FIFO still accepts when its head leaves in the same cycle.
   assign fifo_pop  = !fifo_empty && i_fb_wr_ready;
   assign fifo_push = pix_ok && (!fifo_full || fifo_pop);
   assign drop      = pix_ok && fifo_full && !fifo_pop;
   assign occ_next  = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

   gpu_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (fifo_push),
      .push_data   (push_entry),
      .pop         (fifo_pop),
      .head_data_c (head_raw),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count)
   );

   // Write port presents the FIFO head; payload forced to zero when nothing is queued.
   assign head_entry    = head_raw;
   assign o_fb_wr_valid = !fifo_empty;
   assign o_fb_wr_addr  = fifo_empty ? '0 : ADDR_WIDTH'(head_entry.addr);
   assign o_fb_wr_data  = fifo_empty ? '0 : head_entry.data;

   // Sticky overflow (a drop beats a clear), clip counter and almost-full flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_overflow         <= 1'b0;
         o_clip_count       <= '0;
         o_fifo_almost_full <= 1'b0;
      end else begin
         if (drop)                  o_overflow <= 1'b1;
         else if (i_clear_overflow) o_overflow <= 1'b0;
         if (pix_clip && (o_clip_count != 16'hFFFF)) o_clip_count <= o_clip_count + 16'd1;
         o_fifo_almost_full <= (occ_next >= CNT_W'(FIFO_DEPTH - 1));
      end
   end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer against a queue-based reference model.
module tb_fb_pixel_writer;

   localparam int CW    = 12;
   localparam int DEPTH = 8;
   localparam int FBW   = 640;
   localparam int FBH   = 480;
   localparam int FRAC  = 8;

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          pv;
   logic [CW-1:0] px;
   logic [CW-1:0] py;
   logic [127:0]  pcol;
   logic          rdy;
   logic          clr;
   logic          wr_valid;
   logic [19:0]   wr_addr;
   logic [31:0]   wr_data;
   logic          almost_full;
   logic          overflow;
   logic [15:0]   clip_count;

   int   checks = 0;
   int   errors = 0;
   exp_t mq[$];
   int   m_clip;
   bit   m_ovf;
   bit   m_af;
   int   bx;
   int   by;
   logic [31:0] e_data;

   fb_pixel_writer #(.CORD_WIDTH(CW)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_pixel_valid      (pv),
      .i_pixel_x          (px),
      .i_pixel_y          (py),
      .i_pixel_color      (pcol),
      .o_fb_wr_valid      (wr_valid),
      .i_fb_wr_ready      (rdy),
      .o_fb_wr_addr       (wr_addr),
      .o_fb_wr_data       (wr_data),
      .o_fifo_almost_full (almost_full),
      .o_overflow         (overflow),
      .i_clear_overflow   (clr),
      .o_clip_count       (clip_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int conv(input int c);
      int v;
      if (c < 0) return 0;
      v = c / (1 << (FRAC - 8));
      return (v > 255) ? 255 : v;
   endfunction

   task automatic set_pix(input int x, input int y, input int r, input int g, input int b, input int a);
      pv     = 1'b1;
      bx     = x;
      by     = y;
      px     = CW'(x);
      py     = CW'(y);
      pcol   = {32'(a), 32'(b), 32'(g), 32'(r)};
      e_data = {8'(conv(a)), 8'(conv(b)), 8'(conv(g)), 8'(conv(r))};
   endtask

   task automatic rand_pix(input int x, input int y);
      set_pix(x, y, int'($urandom_range(0, 700)) - 200, int'($urandom_range(0, 700)) - 200,
              int'($urandom_range(0, 700)) - 200, int'($urandom_range(0, 700)) - 200);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 32'(wr_valid), 0);
      chk({tag, "_addr"},  32'(wr_addr), 0);
      chk({tag, "_data"},  wr_data, 0);
      chk({tag, "_af"},    32'(almost_full), 0);
      chk({tag, "_ovf"},   32'(overflow), 0);
      chk({tag, "_clip"},  32'(clip_count), 0);
   endtask

   task automatic model_reset();
      mq.delete();
      m_clip = 0;
      m_ovf  = 1'b0;
      m_af   = 1'b0;
   endtask

   // Compare outputs to the model, then advance the model and the clock by one cycle.
   task automatic tick();
      bit   pop;
      bit   inr;
      bit   was_full;
      exp_t e;
      chk("wr_valid", 32'(wr_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("wr_addr", 32'(wr_addr), mq[0].addr);
         chk("wr_data", wr_data, mq[0].data);
      end
      chk("almost_full", 32'(almost_full), 32'(m_af));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("clip_count", 32'(clip_count), 32'(m_clip));
      pop      = (mq.size() > 0) && rdy;
      inr      = pv && bx >= 0 && bx < FBW && by >= 0 && by < FBH;
      was_full = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      if (inr && (!was_full || pop)) begin
         e.addr = int'(by * FBW + bx);
         e.data = e_data;
         mq.push_back(e);
      end
      if (inr && was_full && !pop) m_ovf = 1'b1;
      else if (clr)                m_ovf = 1'b0;
      if (pv && !inr && m_clip < 65535) m_clip++;
      m_af = (mq.size() >= DEPTH - 1);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; pv = 1'b0; px = '0; py = '0; pcol = '0; rdy = 1'b0; clr = 1'b0;
      bx = 0; by = 0; e_data = '0;
      model_reset();
      @(negedge clk);
      check_zero("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_zero("after_reset");
      @(negedge clk);

      // Single pixel with saturation on R and A.
      rdy = 1'b1;
      set_pix(3, 2, 256, 128, 0, -5);
      tick();
      pv = 1'b0;
      chk("single_valid", 32'(wr_valid), 1);
      chk("single_addr", 32'(wr_addr), 1283);
      chk("single_data", wr_data, 32'h000080FF);
      tick();
      chk("single_one_cycle", 32'(wr_valid), 0);
      tick();

      // Clipping on each edge, then the last on-screen pixel.
      set_pix(-1, 0, 1, 2, 3, 4);   tick();
      set_pix(640, 5, 1, 2, 3, 4);  tick();
      set_pix(0, 480, 1, 2, 3, 4);  tick();
      pv = 1'b0;
      chk("clip_count3", 32'(clip_count), 3);
      chk("clip_no_write", 32'(wr_valid), 0);
      set_pix(639, 479, 10, 20, 30, 40); tick();
      pv = 1'b0;
      chk("corner_addr", 32'(wr_addr), 307199);
      tick(); tick();

      // Backpressure: fill, overflow on the ninth, then drain in order.
      rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin rand_pix(10 + i, i); tick(); end
      pv = 1'b0;
      chk("bp_almost_full", 32'(almost_full), 1);
      chk("bp_no_ovf_yet", 32'(overflow), 0);
      rand_pix(100, 100); tick();
      pv = 1'b0;
      chk("bp_overflow", 32'(overflow), 1);
      tick(); tick();
      rdy = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) tick();
      chk("bp_drained", 32'(wr_valid), 0);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("bp_cleared", 32'(overflow), 0);

      // Full FIFO with a simultaneous pop accepts the new pixel.
      rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin rand_pix(i, 200); tick(); end
      rdy = 1'b1;
      rand_pix(300, 300); tick();
      pv = 1'b0; rdy = 1'b0;
      chk("fullpop_no_ovf", 32'(overflow), 0);
      chk("fullpop_af", 32'(almost_full), 1);
      rdy = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) tick();

      // Drop in the same cycle as a clear keeps the flag set.
      rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin rand_pix(i, 7); tick(); end
      rand_pix(50, 50); clr = 1'b1; tick();
      pv = 1'b0;
      chk("race_ovf_kept", 32'(overflow), 1);
      tick();
      clr = 1'b0;
      chk("race_ovf_clear", 32'(overflow), 0);
      rdy = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) tick();

      // Reset with five queued entries discards them.
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin rand_pix(i, 9); tick(); end
      pv = 1'b0;
      chk("pre_reset_valid", 32'(wr_valid), 1);
      #2 rst_n = 1'b0;
      #1 check_zero("mid_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      rand_pix(1, 1); tick();
      pv = 1'b0;
      tick(); tick();

      // Random traffic with random stalls and clears.
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 3) != 0)
            rand_pix(int'($urandom_range(0, 760)) - 60, int'($urandom_range(0, 560)) - 40);
         else
            pv = 1'b0;
         rdy = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 15) == 0);
         tick();
      end
      pv = 1'b0; clr = 1'b0; rdy = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) tick();
      chk("final_empty", 32'(wr_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
